// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a byte stream (word count, then big-endian words),
// writes each word into IMEM, and holds the CPU pipeline until the load finishes.
module imem_loader (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        LD_start,
  input  logic [7:0]  LD_pc_val,
  input  logic [7:0]  LD_byte,
  input  logic        LD_valid,
  output logic        LD_ready,
  output logic        IMEM_wr_en,
  output logic [31:0] IMEM_wr_addr,
  output logic [31:0] IMEM_wr_data,
  output logic        LD_cpu_hold,
  output logic        LD_busy,
  output logic        LD_done,
  output logic [7:0]  LD_words_written
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  total_q, total_d;
  logic [7:0]  count_q, count_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        ready_q, wr_en_q, busy_q, done_q;

  // Next-state logic; the outgoing word and its address are latched on the last byte
  // so they are stable during WRITE and hold afterwards.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    total_d = total_q;
    count_d = count_q;
    idx_d   = idx_q;
    word_d  = word_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (LD_start) begin
          base_d  = LD_pc_val;
          count_d = 8'd0;
          idx_d   = 2'd0;
          state_d = S_COUNT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COUNT: begin
        if (LD_valid) begin
          total_d = LD_byte;
          state_d = (LD_byte == 8'd0) ? S_DONE : S_DATA;
        end else begin
          state_d = S_COUNT;
        end
      end
      S_DATA: begin
        if (LD_valid) begin
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: word_d[23:16] = LD_byte;
            2'd1: word_d[15:8]  = LD_byte;
            2'd2: word_d[7:0]   = LD_byte;
            2'd3: begin
              data_d  = {word_q, LD_byte};
              addr_d  = {22'd0, base_q, 2'b00} + {22'd0, count_q, 2'b00};
              state_d = S_WRITE;
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_DATA;
        end
      end
      S_WRITE: begin
        count_d = count_q + 8'd1;
        state_d = (count_d == total_q) ? S_DONE : S_DATA;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; control outputs are registered from the next state.
  always_ff @(negedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q <= S_IDLE;
      base_q  <= 8'd0;
      total_q <= 8'd0;
      count_q <= 8'd0;
      idx_q   <= 2'd0;
      word_q  <= 24'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      total_q <= total_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= (state_d == S_COUNT) || (state_d == S_DATA);
      wr_en_q <= (state_d == S_WRITE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign LD_ready         = ready_q;
  assign IMEM_wr_en       = wr_en_q;
  assign IMEM_wr_addr     = addr_q;
  assign IMEM_wr_data     = data_q;
  assign LD_busy          = busy_q;
  assign LD_cpu_hold      = busy_q;
  assign LD_done          = done_q;
  assign LD_words_written = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a stream-level model predicts every IMEM write,
// one compare process checks strobes every cycle, directed loads pin the model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        LD_start;
  logic [7:0]  LD_pc_val;
  logic [7:0]  LD_byte;
  logic        LD_valid;
  logic        LD_ready, IMEM_wr_en, LD_cpu_hold, LD_busy, LD_done;
  logic [31:0] IMEM_wr_addr, IMEM_wr_data;
  logic [7:0]  LD_words_written;

  imem_loader dut (
    .SYS_clk(clk), .SYS_reset(rst), .LD_start(LD_start), .LD_pc_val(LD_pc_val),
    .LD_byte(LD_byte), .LD_valid(LD_valid), .LD_ready(LD_ready),
    .IMEM_wr_en(IMEM_wr_en), .IMEM_wr_addr(IMEM_wr_addr), .IMEM_wr_data(IMEM_wr_data),
    .LD_cpu_hold(LD_cpu_hold), .LD_busy(LD_busy), .LD_done(LD_done),
    .LD_words_written(LD_words_written)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int writes_seen = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Model: expected writes derived from the stream (count byte, then big-endian words).
  function automatic void push_model(logic [7:0] base, logic [7:0] s[$]);
    int n, nw;
    wr_t w;
    n  = s[0];
    nw = (s.size() - 1) / 4;
    if (nw > n) nw = n;
    for (int k = 0; k < nw; k++) begin
      w.addr = 32'(base) * 32'd4 + 32'(k) * 32'd4;
      w.data = {s[1+4*k], s[2+4*k], s[3+4*k], s[4+4*k]};
      exp_q.push_back(w);
    end
  endfunction

  // Compare process: outputs sampled on posedge, away from the active negedge.
  always @(posedge clk) begin
    wr_t w;
    if (!rst) begin
      chk("hold_vs_busy", {31'd0, LD_cpu_hold}, {31'd0, LD_busy});
      if (IMEM_wr_en) begin
        writes_seen++;
        chk("ready_in_write", {31'd0, LD_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("extra_strobe", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr", IMEM_wr_addr, w.addr);
          chk("wr_data", IMEM_wr_data, w.data);
        end
      end
      if (LD_done) begin
        done_seen++;
        chk("ready_in_done", {31'd0, LD_ready}, 32'd0);
      end
    end
  end

  task automatic start_load(input logic [7:0] base);
    @(posedge clk);
    LD_start  = 1'b1;
    LD_pc_val = base;
    @(posedge clk);
    LD_start  = 1'b0;
  endtask

  task automatic send(input logic [7:0] s[$], input bit gaps);
    int idx = 0;
    int budget = 0;
    while (idx < s.size() && budget < 2000) begin
      @(posedge clk);
      budget++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        LD_valid = 1'b0;
      end else begin
        LD_valid = 1'b1;
        LD_byte  = s[idx];
      end
      if (LD_valid && LD_ready) idx++;
    end
    if (idx < s.size()) chk("send_timeout", 32'(idx), 32'(s.size()));
    @(posedge clk);
    LD_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    @(posedge clk);
    while (LD_busy && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    if (LD_busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ready"}, {31'd0, LD_ready}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, IMEM_wr_en}, 32'd0);
    chk({tag, "_addr"}, IMEM_wr_addr, 32'd0);
    chk({tag, "_data"}, IMEM_wr_data, 32'd0);
    chk({tag, "_hold"}, {31'd0, LD_cpu_hold}, 32'd0);
    chk({tag, "_busy"}, {31'd0, LD_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, LD_done}, 32'd0);
    chk({tag, "_words"}, {24'd0, LD_words_written}, 32'd0);
  endtask

  task automatic after_load(string tag, int done_exp, int wr_exp, int ww_exp);
    chk({tag, "_done_count"}, 32'(done_seen), 32'(done_exp));
    chk({tag, "_write_count"}, 32'(writes_seen), 32'(wr_exp));
    chk({tag, "_words_written"}, {24'd0, LD_words_written}, 32'(ww_exp));
    chk({tag, "_hold_released"}, {31'd0, LD_cpu_hold}, 32'd0);
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] s2[$];
    rst = 1'b1; LD_start = 1'b0; LD_pc_val = 8'd0; LD_byte = 8'd0; LD_valid = 1'b0;
    #17;
    chk_all_zero("reset");
    rst = 1'b0;

    // Single word at base 0
    s = '{8'h01, 8'h20, 8'h08, 8'h00, 8'h05};
    start_load(8'h00); push_model(8'h00, s); send(s, 1'b0); wait_idle();
    after_load("one_word", 1, 1, 1);
    chk("one_word_addr", IMEM_wr_addr, 32'h0);
    chk("one_word_data", IMEM_wr_data, 32'h20080005);

    // Three words back-to-back at base 0x10
    s = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
          8'h00, 8'h00, 8'h00, 8'h13};
    start_load(8'h10); push_model(8'h10, s); send(s, 1'b0); wait_idle();
    after_load("three_words", 2, 4, 3);
    chk("three_words_last_addr", IMEM_wr_addr, 32'h48);
    chk("three_words_last_data", IMEM_wr_data, 32'h00000013);

    // Empty load
    s = '{8'h00};
    start_load(8'h07); push_model(8'h07, s); send(s, 1'b0); wait_idle();
    after_load("empty", 3, 4, 0);

    // Random valid gaps
    s = '{8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h01, 8'h02, 8'h03, 8'h04};
    start_load(8'h20); push_model(8'h20, s); send(s, 1'b1); wait_idle();
    after_load("gaps", 4, 6, 2);
    chk("gaps_last_addr", IMEM_wr_addr, 32'h84);

    // LD_start during DATA is ignored
    s  = '{8'h02, 8'hA1, 8'hA2};
    s2 = '{8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    start_load(8'h03); push_model(8'h03, {s, s2}); send(s, 1'b0);
    @(posedge clk); LD_start = 1'b1; LD_pc_val = 8'h55;
    @(posedge clk); LD_start = 1'b0;
    send(s2, 1'b0); wait_idle();
    after_load("start_ignored", 5, 8, 2);
    chk("start_ignored_last_addr", IMEM_wr_addr, 32'h10);
    chk("start_ignored_last_data", IMEM_wr_data, 32'hB1B2B3B4);

    // Reset after 6 of 8 data bytes
    s = '{8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    start_load(8'h08); push_model(8'h08, s); send(s, 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk_all_zero("midreset");
    @(posedge clk); #2 rst = 1'b0;
    chk("midreset_write_count", 32'(writes_seen), 32'd9);
    chk("midreset_done_count", 32'(done_seen), 32'd5);

    // Full load after reset
    s = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    start_load(8'h01); push_model(8'h01, s); send(s, 1'b0); wait_idle();
    after_load("post_reset", 6, 10, 1);
    chk("post_reset_addr", IMEM_wr_addr, 32'h4);
    chk("post_reset_data", IMEM_wr_data, 32'h12345678);

    repeat (3) @(posedge clk);
    chk("missing_strobes", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SYS_clk  in  1  system clock; all state updates on negedge SYS_clk, matching the pipeline.
REQ-002 SYS_reset  in  1  asynchronous, active-high reset.
REQ-003 LD_start  in  1  load request; sampled only in IDLE.
REQ-004 LD_pc_val  in  8  base word index; byte base address = {22'b0, LD_pc_val, 2'b00}; captured on accepted LD_start.
REQ-005 LD_byte  in  8  incoming stream byte.
REQ-006 LD_valid  in  1  LD_byte valid.
REQ-007 LD_ready  out  1  loader can accept a byte; transfer occurs on a negedge with LD_valid=1 and LD_ready=1.
REQ-008 IMEM_wr_en  out  1  one-cycle instruction-memory write strobe.
REQ-009 IMEM_wr_addr  out  32  byte address of the word being written, always word-aligned.
REQ-010 IMEM_wr_data  out  32  assembled instruction word.
REQ-011 LD_cpu_hold  out  1  holds pipeline PC and stage registers while loading.
REQ-012 LD_busy  out  1  high in every state except IDLE.
REQ-013 LD_done  out  1  one-cycle pulse when a load completes.
REQ-014 LD_words_written  out  8  words written in the current or last load.

Function
REQ-015 States: IDLE, COUNT, DATA, WRITE, DONE; encoding free; one state register.
REQ-016 IDLE: LD_ready=0; LD_start=1 -> capture LD_pc_val, clear word counter and byte index, go to COUNT.
REQ-017 COUNT: LD_ready=1; first accepted byte = word total N; N=0 -> DONE, else store N -> DATA.
REQ-018 DATA: LD_ready=1; bytes are big-endian: byte index 0 -> bits 31:24, 1 -> 23:16, 2 -> 15:8, 3 -> 7:0.
REQ-019 DATA: accepting byte index 3 -> WRITE, byte index returns to 0.
REQ-020 WRITE: LD_ready=0; IMEM_wr_en=1 for exactly this cycle.
REQ-021 WRITE: IMEM_wr_addr = base + 4*k, where k = words already written (0-based); IMEM_wr_data = assembled word.
REQ-022 WRITE: word counter increments; counter equal to N -> DONE, else DATA.
REQ-023 DONE: LD_done=1 and LD_ready=0 for one cycle, then IDLE.
REQ-024 IMEM_wr_en is 0 in every state except WRITE; IMEM_wr_addr and IMEM_wr_data hold their last values outside WRITE.
REQ-025 Address arithmetic is 32-bit; base + 4*(N-1) max = 1020 + 1016, no wrap handling needed.
REQ-026 LD_cpu_hold rises with the COUNT entry, stays high through DONE, and falls the cycle after DONE; the pipeline restarts with PC = base.
REQ-027 LD_start in any state other than IDLE is ignored.
REQ-028 LD_valid=0 stalls in COUNT or DATA indefinitely with no state change and no timeout.
REQ-029 Minimum throughput: one byte per cycle in DATA, plus one WRITE bubble per word.
REQ-030 LD_words_written updates in WRITE and holds its value after DONE until the next accepted LD_start clears it.

Reset
REQ-031 SYS_reset=1 immediately forces IDLE, with all outputs 0: LD_ready, IMEM_wr_en, IMEM_wr_addr, IMEM_wr_data, LD_cpu_hold, LD_busy, LD_done, LD_words_written.
REQ-032 Reset mid-load discards the partial word; words already written remain in IMEM; no write strobe is issued during or after reset.

Verification
REQ-033 LD_start, LD_pc_val=0, stream 01 20 08 00 05 -> one write: addr 0x0, data 0x20080005; LD_done pulse; hold released; LD_words_written=1.
REQ-034 LD_pc_val=0x10, N=3, three words, back-to-back valid -> writes to 0x40, 0x44, 0x48 with correct data; LD_ready low during each WRITE cycle.
REQ-035 N=0 -> COUNT -> DONE; no IMEM_wr_en; LD_done pulse; LD_words_written=0.
REQ-036 LD_valid toggles randomly, including gaps mid-word -> same writes as the gap-free stream; no extra or missing strobes.
REQ-037 SYS_reset asserted after 6 of 8 data bytes (N=2) -> exactly one write (word 0) observed; all outputs 0; a subsequent full load succeeds.
REQ-038 LD_start pulsed during DATA -> ignored; base and counter unchanged.
